// File: rtl/ahb2apb_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// ahb2apb_bridge_ctrl : turns each AHB beat into one APB SETUP/ENABLE transfer
// Revision: 1.0
// ============================================================================
module ahb2apb_bridge_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] SLAVE_SPAN = 32'h0400_0000,
    parameter int          NUM_SLAVES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic                  hreadyin,
    input  logic [31:0]           haddr,
    input  logic [31:0]           hwdata,
    output logic [31:0]           hrdata,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [31:0]           paddr,
    output logic [31:0]           pwdata,
    output logic                  pwrite,
    output logic [NUM_SLAVES-1:0] pselx,
    output logic                  penable,
    input  logic [31:0]           prdata
);

    localparam int          c_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [63:0] c_RANGE = 64'(NUM_SLAVES) * {32'd0, SLAVE_SPAN};

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WWAIT  = 3'd1;
    localparam logic [2:0] c_ST_SETUP  = 3'd2;
    localparam logic [2:0] c_ST_ENABLE = 3'd3;
    localparam logic [2:0] c_ST_ERR1   = 3'd4;
    localparam logic [2:0] c_ST_ERR2   = 3'd5;

    logic [2:0]            r_state;
    logic [31:0]           r_addr;
    logic                  r_write;
    logic [NUM_SLAVES-1:0] r_sel;

    logic [31:0]           w_off;
    logic [31:0]           w_idx_full;
    logic                  w_in_range;
    logic                  w_req;
    logic                  w_valid;
    logic                  w_err;
    logic [NUM_SLAVES-1:0] w_sel;
    logic                  w_unused;

    // Both bounds are checked so addresses below BASE_ADDR cannot wrap into range
    always_comb begin
        w_off      = haddr - BASE_ADDR;
        w_in_range = (haddr >= BASE_ADDR) && ({32'd0, w_off} < c_RANGE);
        w_idx_full = w_off / SLAVE_SPAN;
        w_sel      = NUM_SLAVES'(1) << w_idx_full[c_IDX_W-1:0];
        w_req      = hreadyin & htrans[1];
        w_valid    = w_req & w_in_range;
        w_err      = w_req & ~w_in_range;
    end

    assign w_unused  = ^{hsize, hburst, htrans[0], w_idx_full[31:c_IDX_W]};
    assign hreadyout = (r_state == c_ST_IDLE) || (r_state == c_ST_ERR2);
    assign hresp     = ((r_state == c_ST_ERR1) || (r_state == c_ST_ERR2)) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_addr  <= 32'd0;
            r_write <= 1'b0;
            r_sel   <= '0;
            hrdata  <= 32'd0;
            paddr   <= 32'd0;
            pwdata  <= 32'd0;
            pwrite  <= 1'b0;
            pselx   <= '0;
            penable <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_valid) begin
                        r_addr  <= haddr;
                        r_write <= hwrite;
                        r_sel   <= w_sel;
                        if (hwrite) begin
                            r_state <= c_ST_WWAIT;
                        end else begin
                            // Reads skip WWAIT, so the SETUP outputs come straight from the bus
                            pselx   <= w_sel;
                            paddr   <= haddr;
                            pwrite  <= 1'b0;
                            penable <= 1'b0;
                            r_state <= c_ST_SETUP;
                        end
                    end else if (w_err) begin
                        r_state <= c_ST_ERR1;
                    end
                end
                c_ST_WWAIT: begin
                    pwdata  <= hwdata;
                    pselx   <= r_sel;
                    paddr   <= r_addr;
                    pwrite  <= 1'b1;
                    penable <= 1'b0;
                    r_state <= c_ST_SETUP;
                end
                c_ST_SETUP: begin
                    penable <= 1'b1;
                    r_state <= c_ST_ENABLE;
                end
                c_ST_ENABLE: begin
                    if (!r_write) begin
                        hrdata <= prdata;
                    end
                    pselx   <= '0;
                    penable <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                c_ST_ERR1: r_state <= c_ST_ERR2;
                c_ST_ERR2: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb2apb_bridge_ctrl.md
Name: ahb2apb_bridge_ctrl

Overview:
- Synthesizable AHB-to-APB bridge controller. Sits directly downstream of the AHB master and consumes its address/control/data phases.
- Converts each valid AHB transfer into one two-phase APB transfer (SETUP, then ENABLE) on a selected APB slave.
- Stalls the master with hreadyout while the APB transfer is in flight, and returns read data on hrdata.

Parameters:
BASE_ADDR, 32'h8000_0000, lowest decoded address
SLAVE_SPAN, 32'h0400_0000, bytes per APB slave window
NUM_SLAVES, 3, number of APB select lines; decoded range is BASE_ADDR .. BASE_ADDR+NUM_SLAVES*SLAVE_SPAN-1

Ports:
clk  in  1  single clock for AHB and APB sides
rst  in  1  asynchronous, active-high reset
hwrite  in  1  1=write, 0=read
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hsize  in  3  accepted and ignored; APB side is always 32-bit
hburst  in  3  accepted and ignored; each beat is converted independently
hreadyin  in  1  AHB bus ready
haddr  in  32  address-phase address
hwdata  in  32  write data, valid in the cycle after the address phase
hrdata  out  32  read data to master
hreadyout  out  1  transfer-complete / not-stalled
hresp  out  2  00 OKAY, 01 ERROR
paddr  out  32  APB address
pwdata  out  32  APB write data
pwrite  out  1  APB direction
pselx  out  NUM_SLAVES  one-hot APB select
penable  out  1  APB enable phase
prdata  in  32  APB read data

Behaviour:
- Reset (async, immediate on rst=1, including mid-transfer): state=IDLE, hreadyout=1, hresp=00, hrdata=0, paddr=0, pwdata=0, pwrite=0, pselx=0, penable=0.
- valid = hreadyin & htrans[1] & haddr in decoded range. BUSY (01) and IDLE (00) are ignored.
- err_req = hreadyin & htrans[1] & haddr outside range.
- Slave index = (haddr-BASE_ADDR)/SLAVE_SPAN. pselx is the one-hot of that index, e.g. 0x8000_xxxx->001, 0x8400_xxxx->010, 0x8800_xxxx->100.
- Address-phase inputs are sampled only in IDLE. Address, index and hwrite are latched into registers on acceptance.
- hreadyout=1 only in IDLE and ERR2; 0 in all other states. hresp=01 in ERR1 and ERR2, otherwise 00.
- FSM states: IDLE, WWAIT, SETUP, ENABLE, ERR1, ERR2.
  - IDLE: valid & !hwrite -> SETUP. valid & hwrite -> WWAIT. err_req -> ERR1. Otherwise stay.
  - WWAIT: latch hwdata into pwdata -> SETUP.
  - SETUP: pselx=decoded, penable=0, paddr/pwrite driven from latched values -> ENABLE.
  - ENABLE: pselx held, penable=1. If read, prdata is registered into hrdata at the end of this cycle -> IDLE.
  - ERR1 -> ERR2 -> IDLE. No APB activity.
- pselx, penable, paddr, pwrite and pwdata are registered outputs that change only on clk edges. pselx and penable are 0 outside SETUP/ENABLE. paddr, pwdata and pwrite hold their last values.
- Read latency: address sampled in IDLE (cycle 0); SETUP at cycle 1; ENABLE at cycle 2; hrdata valid with hreadyout=1 at cycle 3. This gives 2 wait states.
- Write latency: IDLE (cycle 0), WWAIT (cycle 1), SETUP (cycle 2), ENABLE (cycle 3), hreadyout=1 at cycle 4. This gives 3 wait states.
- hrdata holds its value until the next read's ENABLE. Writes do not modify hrdata.
- Bursts: each NONSEQ/SEQ beat is a separate APB transfer. The next beat's address is sampled in the IDLE cycle that completes the previous beat, so beats run back-to-back with no extra idle cycle.
- The master must hold haddr/hwdata while hreadyout=0. The bridge does not re-sample them outside IDLE/WWAIT.
- hreadyin=0 in IDLE means no transfer is accepted, regardless of htrans.
- Address arithmetic is unsigned 32-bit. The top of the range, BASE_ADDR+NUM_SLAVES*SLAVE_SPAN-1 (0x8BFF_FFFF), is valid; 0x8C00_0000 and 0x7FFF_FFFF are errors.

Test Plan:
- Reset then idle: rst pulse with htrans=00 -> hreadyout=1, pselx=000, penable=0, hresp=00 on every cycle.
- Single read: haddr=0x8000_00A2, htrans=10, hwrite=0, prdata=0xA5A5_0001 -> SETUP cycle 1 (pselx=001, penable=0, paddr=0x8000_00A2), ENABLE cycle 2 (penable=1), cycle 3 hrdata=0xA5A5_0001 and hreadyout=1.
- Single write: haddr=0x8400_0001, hwdata=0xA300_1111 in the next cycle -> pselx=010, pwrite=1, pwdata=0xA300_1111 in SETUP (cycle 2) and ENABLE (cycle 3); hreadyout=1 at cycle 4.
- Burst read: 4 beats at 0x8800_00C0/C4/C8/CC (NONSEQ then SEQ) -> 4 APB transfers with pselx=100 and the exact paddr sequence, each 3 cycles apart; hreadyout low between beats.
- Error: haddr=0x9000_0000, htrans=10 -> ERR1 (hresp=01, hreadyout=0), ERR2 (hresp=01, hreadyout=1), no pselx activity; same result for 0x8C00_0000.
- Reset mid-ENABLE during a read -> pselx=0, penable=0, hreadyout=1, hrdata=0 immediately. A new read after rst deasserts completes normally.
- hreadyin=0 with htrans=10 -> no APB activity and state stays IDLE.
